// File: rtl/ps2_hex_entry.sv
// ps2_hex_entry: PS/2 set-2 scan-code decoder feeding a hex entry buffer.
// Decodes make/break/extended prefixes, suppresses typematic repeats, and
// maintains a right-shifting hex digit buffer with Backspace, Escape and
// Enter (commit). Optional build macro KEYPAD_DIGITS_EN adds numeric keypad
// digits and keypad Enter (E0 5A).
module ps2_hex_entry #(
    parameter  int DIGITS = 8,
    localparam int CNT_W  = $clog2(DIGITS + 1),
    localparam int W      = 4 * DIGITS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       code_in,
    input  logic             code_valid,
    output logic [W-1:0]     entry_out,
    output logic [CNT_W-1:0] digit_count,
    output logic             entry_full,
    output logic [W-1:0]     value_out,
    output logic             value_valid
);

    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ESC   = 8'h76;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] held_code;

    logic       dig_hit;
    logic [3:0] dig_nib;
    logic       make_evt;
    logic       fresh_make;

    // Full flag tracks the counter directly, so it changes in the same
    // cycle as digit_count.
    assign entry_full = (digit_count == CNT_W'(DIGITS));

    // Map the incoming byte to a hex nibble when it is a digit key.
    always_comb begin
        dig_hit = 1'b1;
        dig_nib = 4'h0;
        case (code_in)
            8'h45: dig_nib = 4'h0;
            8'h16: dig_nib = 4'h1;
            8'h1E: dig_nib = 4'h2;
            8'h26: dig_nib = 4'h3;
            8'h25: dig_nib = 4'h4;
            8'h2E: dig_nib = 4'h5;
            8'h36: dig_nib = 4'h6;
            8'h3D: dig_nib = 4'h7;
            8'h3E: dig_nib = 4'h8;
            8'h46: dig_nib = 4'h9;
            8'h1C: dig_nib = 4'hA;
            8'h32: dig_nib = 4'hB;
            8'h21: dig_nib = 4'hC;
            8'h23: dig_nib = 4'hD;
            8'h24: dig_nib = 4'hE;
            8'h2B: dig_nib = 4'hF;
`ifdef KEYPAD_DIGITS_EN
            8'h70: dig_nib = 4'h0;
            8'h69: dig_nib = 4'h1;
            8'h72: dig_nib = 4'h2;
            8'h7A: dig_nib = 4'h3;
            8'h6B: dig_nib = 4'h4;
            8'h73: dig_nib = 4'h5;
            8'h74: dig_nib = 4'h6;
            8'h6C: dig_nib = 4'h7;
            8'h75: dig_nib = 4'h8;
            8'h7D: dig_nib = 4'h9;
`endif
            default: dig_hit = 1'b0;
        endcase
    end

    // A make event is a non-prefix byte seen in IDLE; keypad Enter (E0 5A)
    // also counts when the keypad option is built in. Repeats of the held
    // key are typematic and get filtered out.
    always_comb begin
        make_evt = code_valid && (state == IDLE) &&
                   (code_in != CODE_BRK) && (code_in != CODE_EXT);
`ifdef KEYPAD_DIGITS_EN
        if (code_valid && (state == EXT) && (code_in == CODE_ENTER))
            make_evt = 1'b1;
`endif
        fresh_make = make_evt && (code_in != held_code);
    end

    // Prefix FSM, held-key tracking and entry buffer, all advanced only on
    // code_valid; value_valid self-clears every cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            held_code   <= 8'h00;
            entry_out   <= '0;
            digit_count <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (code_valid) begin
                case (state)
                    IDLE: begin
                        if (code_in == CODE_BRK)
                            state <= BRK;
                        else if (code_in == CODE_EXT)
                            state <= EXT;
                    end
                    BRK: begin
                        if (code_in == held_code)
                            held_code <= 8'h00;
                        state <= IDLE;
                    end
                    EXT: begin
                        if (code_in == CODE_BRK)
                            state <= EXT_BRK;
                        else if (code_in != CODE_EXT)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase

                if (fresh_make) begin
                    held_code <= code_in;
                    if (dig_hit) begin
                        if (!entry_full) begin
                            entry_out   <= {entry_out[W-5:0], dig_nib};
                            digit_count <= digit_count + CNT_W'(1);
                        end
                    end else begin
                        case (code_in)
                            CODE_BKSP: begin
                                if (digit_count != '0) begin
                                    entry_out   <= entry_out >> 4;
                                    digit_count <= digit_count - CNT_W'(1);
                                end
                            end
                            CODE_ESC: begin
                                entry_out   <= '0;
                                digit_count <= '0;
                            end
                            CODE_ENTER: begin
                                if (digit_count != '0) begin
                                    value_out   <= entry_out;
                                    value_valid <= 1'b1;
                                    entry_out   <= '0;
                                    digit_count <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Self-checking bench for ps2_hex_entry: directed scenarios followed by a
// random scan-code stream, compared against a key-level reference model.
module tb_ps2_hex_entry;

    localparam int DIGITS = 8;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int W      = 4 * DIGITS;

    logic             CLK = 1'b0;
    logic             RST;
    logic [7:0]       code_in;
    logic             code_valid;
    logic [W-1:0]     entry_out;
    logic [CNT_W-1:0] digit_count;
    logic             entry_full;
    logic [W-1:0]     value_out;
    logic             value_valid;

    int checks = 0;
    int failures = 0;

    ps2_hex_entry #(.DIGITS(DIGITS)) dut (
        .CLK(CLK), .RST(RST), .code_in(code_in), .code_valid(code_valid),
        .entry_out(entry_out), .digit_count(digit_count),
        .entry_full(entry_full), .value_out(value_out),
        .value_valid(value_valid)
    );

    always #5 CLK = ~CLK;

    // Reference model: digits kept as a list (oldest first), plus the
    // prefix context a keyboard byte stream implies.
    logic [3:0]  m_digs[$];
    logic [7:0]  m_held;
    bit          m_brk_pending, m_in_ext, m_ext_brk;
    logic [W-1:0] m_value;
    bit          m_pulse;

    logic [7:0] hex_codes[16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                  8'h36, 8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32,
                                  8'h21, 8'h23, 8'h24, 8'h2B};
    logic [7:0] kp_codes[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73,
                                  8'h74, 8'h6C, 8'h75, 8'h7D};

    function automatic logic [W-1:0] m_entry();
        logic [W-1:0] v = '0;
        foreach (m_digs[i]) v = (v << 4) | W'(m_digs[i]);
        return v;
    endfunction

    function automatic void m_reset();
        m_digs.delete();
        m_held = 8'h00;
        m_brk_pending = 0; m_in_ext = 0; m_ext_brk = 0;
        m_value = '0;
        m_pulse = 0;
    endfunction

    function automatic int m_digit_of(logic [7:0] b);
        foreach (hex_codes[i]) if (hex_codes[i] == b) return i;
`ifdef KEYPAD_DIGITS_EN
        foreach (kp_codes[i]) if (kp_codes[i] == b) return i;
`endif
        return -1;
    endfunction

    function automatic void m_make(logic [7:0] b);
        int d;
        if (b == m_held) return;
        m_held = b;
        d = m_digit_of(b);
        if (d >= 0) begin
            if (m_digs.size() < DIGITS) m_digs.push_back(4'(d));
        end else if (b == 8'h66) begin
            if (m_digs.size() > 0) void'(m_digs.pop_back());
        end else if (b == 8'h76) begin
            m_digs.delete();
        end else if (b == 8'h5A) begin
            if (m_digs.size() > 0) begin
                m_value = m_entry();
                m_pulse = 1;
                m_digs.delete();
            end
        end
    endfunction

    function automatic void m_byte(logic [7:0] b);
        m_pulse = 0;
        if (m_brk_pending) begin
            if (b == m_held) m_held = 8'h00;
            m_brk_pending = 0;
        end else if (m_ext_brk) begin
            m_ext_brk = 0;
            m_in_ext = 0;
        end else if (m_in_ext) begin
            if (b == 8'hF0) m_ext_brk = 1;
            else if (b != 8'hE0) begin
                m_in_ext = 0;
`ifdef KEYPAD_DIGITS_EN
                if (b == 8'h5A) m_make(b);
`endif
            end
        end else if (b == 8'hF0) m_brk_pending = 1;
        else if (b == 8'hE0) m_in_ext = 1;
        else m_make(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".entry"}, 64'(entry_out), 64'(m_entry()));
        check({tag, ".count"}, 64'(digit_count), 64'(m_digs.size()));
        check({tag, ".full"},  64'(entry_full), 64'(m_digs.size() == DIGITS));
        check({tag, ".value"}, 64'(value_out), 64'(m_value));
        check({tag, ".vvalid"}, 64'(value_valid), 64'(m_pulse));
    endtask

    // Strobe one byte, then compare at the following falling edge. After a
    // commit, confirm the pulse lasts exactly one cycle.
    task automatic send(input logic [7:0] b, input string tag);
        @(negedge CLK);
        code_in = b;
        code_valid = 1'b1;
        m_byte(b);
        @(negedge CLK);
        code_valid = 1'b0;
        check_all(tag);
        if (m_pulse) begin
            m_pulse = 0;
            @(negedge CLK);
            check({tag, ".pulse_end"}, 64'(value_valid), 64'd0);
            check({tag, ".value_hold"}, 64'(value_out), 64'(m_value));
        end
    endtask

    task automatic key(input logic [7:0] b, input string tag);
        send(b, tag);
        send(8'hF0, tag);
        send(b, tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        m_reset();
        @(negedge CLK);
        check_all("reset");
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        code_in = 8'h00;
        code_valid = 1'b0;
        m_reset();
        repeat (2) @(negedge CLK);
        check_all("reset_init");
        RST = 1'b0;

        // 1,2,3 with breaks
        key(8'h16, "d1"); key(8'h1E, "d2"); key(8'h26, "d3");
        check("plan1.entry", 64'(entry_out), 64'h123);

        // typematic suppression
        key(8'h76, "esc");
        send(8'h1C, "tm"); send(8'h1C, "tm"); send(8'h1C, "tm");
        send(8'hF0, "tm"); send(8'h1C, "tm"); send(8'h1C, "tm");
        check("plan2.entry", 64'(entry_out), 64'hAA);

        // fill, overflow, backspace
        key(8'h76, "esc2");
        for (int i = 1; i <= 8; i++) key(hex_codes[i], "fill");
        check("plan3.full", 64'(entry_full), 64'd1);
        key(hex_codes[9], "over");
        check("plan3.over", 64'(entry_out), 64'h12345678);
        key(8'h66, "bksp");
        check("plan3.bksp", 64'(entry_out), 64'h1234567);
        check("plan3.cnt", 64'(digit_count), 64'd7);

        // commit, then Enter on empty buffer
        key(8'h76, "esc3");
        key(8'h2B, "F"); key(8'h45, "0");
        send(8'h5A, "enter");
        check("plan4.value", 64'(value_out), 64'hF0);
        send(8'hF0, "enter"); send(8'h5A, "enter");
        key(8'h5A, "enter_empty");
        check("plan4.value2", 64'(value_out), 64'hF0);

        // reset after a break prefix
        send(8'hF0, "pre_rst");
        do_reset();
        send(8'h16, "post_rst");
        check("plan5.entry", 64'(entry_out), 64'h1);

        // keypad digit and keypad Enter
        do_reset();
        send(8'h69, "kp"); send(8'hF0, "kp"); send(8'h69, "kp");
        send(8'hE0, "kp"); send(8'h5A, "kp_enter");
        send(8'hE0, "kp"); send(8'hF0, "kp"); send(8'h5A, "kp");
`ifdef KEYPAD_DIGITS_EN
        check("plan6.value", 64'(value_out), 64'h1);
`else
        check("plan6.value", 64'(value_out), 64'h0);
`endif

        // random byte stream
        for (int n = 0; n < 600; n++) begin
            logic [7:0] b;
            int sel = $urandom_range(0, 99);
            if (sel < 40)      b = hex_codes[$urandom_range(0, 15)];
            else if (sel < 60) b = 8'hF0;
            else if (sel < 66) b = 8'hE0;
            else if (sel < 72) b = 8'h66;
            else if (sel < 75) b = 8'h76;
            else if (sel < 84) b = 8'h5A;
            else if (sel < 94) b = kp_codes[$urandom_range(0, 9)];
            else               b = 8'($urandom_range(0, 255));
            send(b, "rand");
            if (n == 300) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_hex_entry.md
Name: ps2_hex_entry

Overview:
- Consumes 8-bit PS/2 set-2 scan codes from the keyboard receiver stage, one per `code_valid` strobe.
- Decodes make/break/extended prefixes and suppresses typematic repeats.
- Turns hex-digit keypresses into a right-shifting entry buffer, with Backspace, Escape (clear) and Enter (commit).
- Feeds committed numbers (private key, modulus, etc.) to the key-exchange datapath and the live buffer to the display.

Parameters:
- DIGITS, 8, maximum hex digits in the entry buffer (value width = 4*DIGITS).
- CNT_W, $clog2(DIGITS+1), width of the digit counter. Derived; do not override.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- code_in  input  8  scan code byte from the receiver; sampled only when `code_valid`=1.
- code_valid  input  1  one-cycle strobe; one strobe per received byte.
- entry_out  output  4*DIGITS  live entry buffer; newest digit in [3:0].
- digit_count  output  CNT_W  digits currently in the buffer, 0..DIGITS.
- entry_full  output  1  high when `digit_count`==DIGITS.
- value_out  output  4*DIGITS  last committed value; holds until the next commit.
- value_valid  output  1  one-cycle pulse when `value_out` updates.

Behaviour:
- Reset (async, RST=1):
  - All outputs 0.
  - FSM to IDLE.
  - `held_code` cleared to 0x00.
  - Reset mid-sequence (e.g. after F0 or E0) discards the prefix.
- All state updates happen on the CLK edge where `code_valid`=1; response is visible the next cycle (1-cycle latency). Without `code_valid`, nothing changes.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
- IDLE:
  - 0xF0 -> BRK.
  - 0xE0 -> EXT.
  - Any other byte is a make code: processed as below, stay IDLE.
- BRK: any byte is a break code. If byte==`held_code`, clear `held_code` to 0x00. Go to IDLE. No buffer action.
- EXT:
  - 0xF0 -> EXT_BRK.
  - 0xE0 -> stay EXT.
  - Any other byte -> IDLE, ignored (see Optional Feature).
- EXT_BRK: any byte -> IDLE, ignored.
- Make processing:
  - If byte==`held_code`, it is a repeat: ignore it.
  - Otherwise set `held_code`=byte, then act on the byte as below.
- Hex digit keys:
  - Codes: 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46, A=1C, B=32, C=21, D=23, E=24, F=2B (hex).
  - If not full: entry_out <= {entry_out[4*DIGITS-5:0], nibble}, count+1.
  - If full: digit dropped, buffer unchanged.
- Backspace 0x66:
  - If count>0: entry_out <= entry_out>>4, count-1.
  - At count 0: no effect.
- Escape 0x76: entry_out<=0, count<=0. `value_out` is untouched.
- Enter 0x5A:
  - If count>0: value_out<=entry_out, value_valid=1 for exactly one cycle, then entry_out<=0, count<=0.
  - At count 0: ignored, no pulse.
- Any other make code: only updates `held_code`, no buffer action.
- `value_valid` is 0 on every cycle except commit cycles. Back-to-back commits need two Enter strobes, and the second still needs count>0.
- `entry_full` is combinational from `digit_count`, or registered with identical timing.

Optional Feature:
- Macro: KEYPAD_DIGITS_EN.
- Defined:
  - Numeric keypad makes are accepted as digits 0-9: 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D (hex).
  - Keypad Enter (E0 5A) acts as Enter. Its following E0 F0 5A is consumed by EXT_BRK.
  - `held_code` tracks keypad Enter as 0x5A.
- Undefined: keypad codes are "other" make codes (no buffer action), and E0 5A is ignored.

Test Plan:
- Reset, then strobe 16,1E,26 with F0-break after each -> entry_out=0x123, digit_count=3, value_valid never high.
- Strobe 1C,1C,1C (typematic, no break), then F0 1C, then 1C -> exactly two digits A entered, entry_out=0xAA.
- Enter 8 digits (DIGITS=8) then a 9th digit; then 66 -> full=1 with 9th ignored; after Backspace count=7, entry_out shifted right 4.
- Type 2B,45 then 5A -> value_out=0xF0 with value_valid one cycle, entry_out=0, count=0; a second 5A with empty buffer -> no pulse.
- Send F0 then assert RST mid-sequence, release, strobe 16 -> treated as make, entry_out=0x1.
- With KEYPAD_DIGITS_EN: 69,F0,69,E0,5A -> value_out=0x1 pulse; without the macro: no digit, no pulse, entry_out=0.
